// File: rtl/circuito_pwm_core_pkg.sv
// Shared types for the servo PWM core.
//
// Contents:
//   LarguraW   - width of the pulse-width selector
//   largura_t  - pulse-width selector type (any of the eight codes is legal)
package circuito_pwm_core_pkg;

    localparam int unsigned LarguraW = 3;

    typedef logic [LarguraW-1:0] largura_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M up-counter.
//
// Counts 0 .. M-1 and wraps to 0 while conta is high. zera_s clears
// synchronously and has priority over conta.
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset (Q = 0)
//   zera_s  - synchronous clear
//   conta   - count enable
//   Q       - current count, N bits
//   fim     - high while Q == M-1
//   meio    - high while Q == M/2-1
module contador_m #(
    parameter int unsigned M = 10,
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera_s,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio
);

    localparam logic [N-1:0] Ultimo = N'(M - 1);
    localparam logic [N-1:0] Metade = N'(M / 2 - 1);

    logic [N-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (zera_s) begin
            q_d = '0;
        end else if (conta) begin
            q_d = (q_q == Ultimo) ? '0 : q_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign fim  = (q_q == Ultimo);
    assign meio = (q_q == Metade);

endmodule

// File: rtl/circuito_pwm_core.sv
// Servo-style PWM generator: fixed period, eight selectable high times.
//
// The period counter runs 0 .. conf_periodo-1. Each edge the output register
// takes (contagem < active width), so pwm lags the counter by one cycle and
// stays high for exactly "active width" cycles per period.
//
// By default the active width is latched from largura on the last cycle of
// each period, so a mid-period change only affects the next period and pulses
// are never truncated. Defining PWM_IMMEDIATE_UPDATE_EN bypasses the latch and
// compares against the live selection every cycle.
//
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset (counter 0, width largura_000, pwm 0)
//   largura  - 3-bit pulse-width selector
//   pwm      - registered PWM output
//
// Build option: PWM_IMMEDIATE_UPDATE_EN
module circuito_pwm_core
    import circuito_pwm_core_pkg::*;
#(
    parameter int unsigned conf_periodo = 1000000,
    parameter int unsigned largura_000  = 35000,
    parameter int unsigned largura_001  = 45700,
    parameter int unsigned largura_010  = 56450,
    parameter int unsigned largura_011  = 67150,
    parameter int unsigned largura_100  = 77850,
    parameter int unsigned largura_101  = 88550,
    parameter int unsigned largura_110  = 99300,
    parameter int unsigned largura_111  = 110000
) (
    input  logic     clock,
    input  logic     reset,
    input  largura_t largura,
    output logic     pwm
);

    localparam int unsigned N = (conf_periodo > 1) ? $clog2(conf_periodo) : 1;

    // Widths are compared at counter width; wider values are truncated.
    localparam logic [N-1:0] L000 = N'(largura_000);
    localparam logic [N-1:0] L001 = N'(largura_001);
    localparam logic [N-1:0] L010 = N'(largura_010);
    localparam logic [N-1:0] L011 = N'(largura_011);
    localparam logic [N-1:0] L100 = N'(largura_100);
    localparam logic [N-1:0] L101 = N'(largura_101);
    localparam logic [N-1:0] L110 = N'(largura_110);
    localparam logic [N-1:0] L111 = N'(largura_111);

    function automatic logic [N-1:0] seleciona(input largura_t sel);
        logic [N-1:0] w;
        unique case (sel)
            3'b000: w = L000;
            3'b001: w = L001;
            3'b010: w = L010;
            3'b011: w = L011;
            3'b100: w = L100;
            3'b101: w = L101;
            3'b110: w = L110;
            3'b111: w = L111;
        endcase
        return w;
    endfunction

    logic [N-1:0] contagem;
    logic         fim;
    logic         meio_unused;
    logic [N-1:0] largura_ativa;
    logic         pwm_d, pwm_q;

    contador_m #(
        .M (conf_periodo),
        .N (N)
    ) u_contador (
        .clock  (clock),
        .reset  (reset),
        .zera_s (1'b0),
        .conta  (1'b1),
        .Q      (contagem),
        .fim    (fim),
        .meio   (meio_unused)
    );

`ifdef PWM_IMMEDIATE_UPDATE_EN
    logic fim_unused;

    assign fim_unused    = fim;
    assign largura_ativa = seleciona(largura);
`else
    logic [N-1:0] largura_reg_d, largura_reg;

    // Reload only on the last cycle of the period so every pulse is whole.
    always_comb begin
        largura_reg_d = largura_reg;
        if (fim) begin
            largura_reg_d = seleciona(largura);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            largura_reg <= L000;
        end else begin
            largura_reg <= largura_reg_d;
        end
    end

    assign largura_ativa = largura_reg;
`endif

    // Unsigned compare: width 0 never drives high, width >= period never drops.
    always_comb begin
        pwm_d = (contagem < largura_ativa);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: tb/tb_circuito_pwm_core.sv
// Directed bench for circuito_pwm_core using a short 20-cycle period so that
// many whole periods fit in a brief run. Each observation window covers one
// period, starting with the sample taken after the first edge of that period.
module tb_circuito_pwm_core;

    localparam int unsigned P = 20;

    logic       clock;
    logic       reset;
    logic [2:0] largura;
    logic       pwm;

    int tests;
    int falhas;

    circuito_pwm_core #(
        .conf_periodo (P),
        .largura_000  (3),
        .largura_001  (5),
        .largura_010  (7),
        .largura_011  (9),
        .largura_100  (0),
        .largura_101  (12),
        .largura_110  (15),
        .largura_111  (25)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .largura (largura),
        .pwm     (pwm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        tests++;
        assert (obs === esp)
        else begin
            falhas++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
        end
    endtask

    // Observe one period. largura is switched to 'novo' at sample index 'idx'
    // (idx <= P-2 so it lands before the reload edge). 'esp' is the high time
    // expected for this period.
    task automatic janela(input logic [2:0] novo, input int idx, input int esp,
                          input string tag);
        int          alto;
        int          forma_err;
        logic [31:0] c_ini, c_penult, c_fim;
        alto      = 0;
        forma_err = 0;
        c_ini     = '0;
        c_penult  = '0;
        c_fim     = '0;
        for (int i = 0; i < int'(P); i++) begin
            @(negedge clock);
            if (pwm === 1'b1) alto++;
            if (pwm !== ((i < esp) ? 1'b1 : 1'b0)) forma_err++;
            if (i == 0) c_ini = 32'(dut.contagem);
            if (i == int'(P) - 2) c_penult = 32'(dut.contagem);
            if (i == int'(P) - 1) c_fim = 32'(dut.contagem);
            if (i == idx) largura = novo;
        end
        verifica({tag, "_alto"}, alto, esp);
        verifica({tag, "_forma"}, forma_err, 0);
        verifica({tag, "_cont_ini"}, c_ini, 1);
        verifica({tag, "_cont_max"}, c_penult, P - 1);
        verifica({tag, "_cont_wrap"}, c_fim, 0);
    endtask

    initial begin
        tests   = 0;
        falhas  = 0;
        reset   = 1'b0;
        largura = 3'b000;

        #3;
        verifica("rst_pwm", pwm, 0);
        verifica("rst_cont", dut.contagem, 0);
        @(negedge clock);
        @(negedge clock);
        verifica("rst_hold_pwm", pwm, 0);
        reset = 1'b1;

        // 000 -> 111 mid-pulse: current pulse still 3, next one constant high.
        janela(3'b111, 1, 3, "w000_sw111");
        janela(3'b100, 0, 20, "w111");
        janela(3'b001, 10, 0, "w100");
        janela(3'b010, 2, 5, "w001");
        janela(3'b011, int'(P) - 2, 7, "w010");
        janela(3'b101, 5, 9, "w011");
        janela(3'b110, 5, 12, "w101");
        janela(3'b000, 5, 15, "w110");
        janela(3'b111, 5, 3, "w000");

        // Mid-pulse reset while 111 is pending: outputs clear at once and the
        // first period after release uses largura_000.
        @(negedge clock);
        @(negedge clock);
        verifica("pre_rst_pwm", pwm, 1);
        #2;
        reset = 1'b0;
        #1;
        verifica("mid_rst_pwm", pwm, 0);
        verifica("mid_rst_cont", dut.contagem, 0);
        @(negedge clock);
        verifica("mid_rst_hold", pwm, 0);
        reset = 1'b1;
        janela(3'b000, 5, 3, "pos_rst");
        janela(3'b000, 5, 3, "pos_rst2");

        $display("[TB] %0d tests run, %0d failed", tests, falhas);
        $finish;
    end

endmodule

// File: doc/circuito_pwm_core.md
Name: circuito_pwm_core

Overview:
Servo-style PWM generator with a fixed period and eight selectable pulse widths chosen by a 3-bit input. It sits between the control logic that picks a servo position and the physical PWM pin. The default timing gives a 20 ms period and 0.7–2.2 ms pulses at a 50 MHz clock.

Parameters:
conf_periodo, 1000000, PWM period in clock cycles (20 ms at 50 MHz).
largura_000, 35000, high time in cycles for largura=3'b000 (0.70 ms).
largura_001, 45700, high time for 3'b001.
largura_010, 56450, high time for 3'b010.
largura_011, 67150, high time for 3'b011.
largura_100, 77850, high time for 3'b100.
largura_101, 88550, high time for 3'b101.
largura_110, 99300, high time for 3'b110.
largura_111, 110000, high time for 3'b111 (2.20 ms).

Ports:
clock    input   1  system clock; all state updates on the rising edge.
reset    input   1  asynchronous, active-low reset.
largura  input   3  pulse-width selector.
pwm      output  1  registered PWM output.

Behaviour:
- Counter width is N = $clog2(conf_periodo).
- The period counter (contagem) runs 0 .. conf_periodo-1 and wraps to 0, incrementing every cycle.
- The width register (largura_reg) holds the active high time in cycles.
  - At each cycle where contagem == conf_periodo-1, largura_reg loads the parameter selected by the current largura input.
  - A change of largura in mid-period takes effect at the start of the next period; there are no glitches or truncated pulses.
- Output rule: each edge, pwm <= (contagem < largura_reg), where contagem is the value before its increment.
  - pwm therefore lags the counter by one cycle.
  - pwm is high for exactly largura_reg consecutive cycles, then low for conf_periodo - largura_reg cycles.
- Reset, asserted low at any time including mid-pulse:
  - contagem = 0, largura_reg = largura_000, pwm = 0, all immediately.
  - After release, the first rising edge sets pwm = 1 (when largura_000 > 0).
  - The first post-reset period always uses largura_000.
- Boundaries:
  - Width 0: pwm constantly 0.
  - Width >= conf_periodo: pwm constantly 1.
  - Comparisons are unsigned at N bits; parameters are truncated to N bits.
- Any 3-bit value of largura is legal; there are no X or hold states.

Optional Feature:
Macro PWM_IMMEDIATE_UPDATE_EN.
- Defined: largura_reg is bypassed. The comparison uses the parameter selected by the live largura input every cycle, so a width change affects the current period, which may produce one shortened or extended pulse.
- Undefined (default): period-boundary latching as described in Behaviour.
- Reset values and pwm registering are identical in both builds.

Decomposition:
- No shared package is needed; the eight widths stay as module parameters.
- A local function or case statement maps largura to its parameter.
- One natural sub-module is contador_m: a modulo-M up-counter.
  - Parameters: M, N.
  - Ports: clock, reset (async active-low), zera_s (sync clear), conta (enable), Q[N-1:0], fim (Q == M-1), meio (unused).
  - The top level instantiates it with M = conf_periodo and uses fim as the latch strobe for largura_reg.

Test Plan:
1. Reset pulse low for 1 cycle mid-operation -> pwm = 0 immediately and contagem = 0; pwm rises 1 cycle after release.
2. largura=3'b000, run 1,000,100 cycles with default params -> pwm high 35000 cycles (700 us), low 965000, period exactly 1,000,000 cycles.
3. Sweep 3'b001..3'b111, each held for one full period plus 100 cycles -> high times 45700, 56450, 67150, 77850, 88550, 99300, 110000 cycles respectively; period unchanged.
4. Switch largura 000->111 in mid-pulse at contagem=10000 -> current pulse still ends at 35000; next pulse lasts 110000 cycles (with PWM_IMMEDIATE_UPDATE_EN: current pulse extends to 110000).
5. Small-parameter build (conf_periodo=10, largura_000=0, largura_111=10) -> 000 gives pwm constant 0, 111 gives constant 1; wrap from 9 to 0 verified.
